// File: rtl/btn_debounce_bank.sv
// Bank of independent push-button debouncers with press/release edge pulses,
// long-press detection and auto-repeat while held.
module btn_debounce_bank #(
  parameter int N_CH          = 4,
  parameter int DEB_CYCLES    = 1000000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            any_press
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  // A zero repeat period still needs a legal one-bit counter.
  localparam int RW = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = (REPEAT_CYCLES > 0) ? RW'(REPEAT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q, sync2_d;
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] press_q, press_d;
  logic [N_CH-1:0] release_q, release_d;
  logic [N_CH-1:0] long_q, long_d;
  logic [N_CH-1:0] repeat_q, repeat_d;
  logic [DW-1:0]   deb_cnt_q  [N_CH];
  logic [DW-1:0]   deb_cnt_d  [N_CH];
  logic [HW-1:0]   hold_cnt_q [N_CH];
  logic [HW-1:0]   hold_cnt_d [N_CH];
  logic [RW-1:0]   rep_cnt_q  [N_CH];
  logic [RW-1:0]   rep_cnt_d  [N_CH];
  state_t          state_q    [N_CH];
  state_t          state_d    [N_CH];

  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;

  // Synchroniser, debounce counters, edge detection and hold FSM next state.
  always_comb begin
    sync1_d   = btn_in;
    sync2_d   = sync1_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    repeat_d  = '0;
    rise      = '0;
    fall      = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      deb_cnt_d[i]  = deb_cnt_q[i];
      hold_cnt_d[i] = hold_cnt_q[i];
      rep_cnt_d[i]  = rep_cnt_q[i];
      state_d[i]    = state_q[i];

      if (sync2_q[i] == level_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_cnt_d[i] = '0;
        level_d[i]   = ~level_q[i];
        rise[i]      = ~level_q[i];
        fall[i]      = level_q[i];
      end else if (deb_cnt_q[i] != '1) begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end

      press_d[i]   = rise[i];
      release_d[i] = fall[i];

      // Release is checked first so it wins over a coinciding threshold.
      unique case (state_q[i])
        IDLE: begin
          if (rise[i]) begin
            state_d[i]    = PRESSED;
            hold_cnt_d[i] = '0;
          end
        end
        PRESSED: begin
          if (fall[i]) begin
            state_d[i] = IDLE;
          end else if (hold_cnt_q[i] == HOLD_LAST) begin
            long_d[i]    = 1'b1;
            state_d[i]   = HELD;
            rep_cnt_d[i] = '0;
          end else if (hold_cnt_q[i] != '1) begin
            hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
          end
        end
        HELD: begin
          if (fall[i]) begin
            state_d[i] = IDLE;
          end else if (REPEAT_CYCLES > 0) begin
            if (rep_cnt_q[i] == REP_LAST) begin
              repeat_d[i]  = 1'b1;
              rep_cnt_d[i] = '0;
            end else if (rep_cnt_q[i] != '1) begin
              rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
            end
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        deb_cnt_q[i]  <= '0;
        hold_cnt_q[i] <= '0;
        rep_cnt_q[i]  <= '0;
        state_q[i]    <= IDLE;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        deb_cnt_q[i]  <= deb_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
        rep_cnt_q[i]  <= rep_cnt_d[i];
        state_q[i]    <= state_d[i];
      end
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign any_press     = |press_q;

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Self-checking bench for btn_debounce_bank: directed scenarios plus random
// button activity, compared against a timestamp-based behavioural model.
`timescale 1ns/1ps
module tb_btn_debounce_bank;

  localparam int N    = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic         any_press;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  btn_debounce_bank #(
    .N_CH(N),
    .DEB_CYCLES(DEB),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse),
    .any_press(any_press)
  );

  // Reference model: input delay line, run length of disagreeing samples,
  // and long/repeat events derived from the age of the current press.
  logic [N-1:0] m_level, m_press, m_release, m_long, m_repeat;
  logic [N-1:0] m_d1, m_d2;
  int           m_run [N];
  int           m_press_edge [N];
  int           m_edge;

  always @(posedge clk or posedge rst) begin
    logic [N-1:0] lv, pr, rl, lg, rp;
    int           run [N];
    int           pe [N];
    int           e, age;
    if (rst) begin
      m_level   <= '0;
      m_press   <= '0;
      m_release <= '0;
      m_long    <= '0;
      m_repeat  <= '0;
      m_d1      <= '0;
      m_d2      <= '0;
      m_edge    <= 0;
      for (int c = 0; c < N; c++) begin
        m_run[c]        <= 0;
        m_press_edge[c] <= 0;
      end
    end else begin
      lv  = m_level;
      run = m_run;
      pe  = m_press_edge;
      e   = m_edge + 1;
      pr  = '0;
      rl  = '0;
      lg  = '0;
      rp  = '0;
      for (int c = 0; c < N; c++) begin
        if (m_d2[c] != lv[c]) begin
          run[c] = run[c] + 1;
          if (run[c] == DEB) begin
            run[c] = 0;
            lv[c]  = ~lv[c];
            if (lv[c]) begin
              pr[c] = 1'b1;
              pe[c] = e;
            end else begin
              rl[c] = 1'b1;
            end
          end
        end else begin
          run[c] = 0;
        end
        if (lv[c] && !pr[c]) begin
          age = e - pe[c];
          if (age == HOLD) lg[c] = 1'b1;
          else if (REP > 0 && age > HOLD && ((age - HOLD) % REP) == 0) rp[c] = 1'b1;
        end
      end
      m_level      <= lv;
      m_press      <= pr;
      m_release    <= rl;
      m_long       <= lg;
      m_repeat     <= rp;
      m_run        <= run;
      m_press_edge <= pe;
      m_edge       <= e;
      m_d2         <= m_d1;
      m_d1         <= btn_in;
    end
  end

  task automatic settle();
    btn_in = '0;
    repeat (14) @(negedge clk);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    btn_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0",
               {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press} !== '0) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=0",
               {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press});
    end
  endtask

  task automatic test_press();
    btn_in = 2'b01;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press} !==
          {m_level, m_press, m_release, m_long, m_repeat, |m_press}) begin
        failures++;
        $display("FAIL press_model k=%0d got=%b exp=%b", k,
                 {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press},
                 {m_level, m_press, m_release, m_long, m_repeat, |m_press});
      end
      checks++;
      if ({btn_level, press_pulse} !== {(k >= 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00}) begin
        failures++;
        $display("FAIL press_latency k=%0d level=%b press=%b", k, btn_level, press_pulse);
      end
    end
    btn_in = 2'b00;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (release_pulse !== ((k == 6) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL release_latency k=%0d got=%b", k, release_pulse);
      end
    end
    settle();
  endtask

  task automatic test_glitch();
    btn_in = 2'b01;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse} !== '0 ||
          {btn_level, press_pulse} !== {m_level, m_press}) begin
        failures++;
        $display("FAIL glitch k=%0d got=%b exp=0", k,
                 {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse});
      end
      if (k == 3) btn_in = 2'b00;
    end
    settle();
  endtask

  task automatic test_hold();
    btn_in = 2'b01;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press} !==
          {m_level, m_press, m_release, m_long, m_repeat, |m_press}) begin
        failures++;
        $display("FAIL hold_model k=%0d got=%b exp=%b", k,
                 {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press},
                 {m_level, m_press, m_release, m_long, m_repeat, |m_press});
      end
      checks++;
      if ({long_pulse[0], repeat_pulse[0], release_pulse[0]} !==
          {k == 16, k == 19 || k == 22 || k == 25 || k == 28 || k == 31, k == 32}) begin
        failures++;
        $display("FAIL hold_timing k=%0d got=%b exp=%b", k,
                 {long_pulse[0], repeat_pulse[0], release_pulse[0]},
                 {k == 16, k == 19 || k == 22 || k == 25 || k == 28 || k == 31, k == 32});
      end
      if (k == 26) btn_in = 2'b00;
    end
    settle();
  endtask

  task automatic test_release_on_long();
    btn_in = 2'b01;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      checks++;
      if ({press_pulse[0], long_pulse[0], repeat_pulse[0], release_pulse[0]} !==
          {k == 6, 1'b0, 1'b0, k == 16}) begin
        failures++;
        $display("FAIL release_prio k=%0d got=%b exp=%b", k,
                 {press_pulse[0], long_pulse[0], repeat_pulse[0], release_pulse[0]},
                 {k == 6, 1'b0, 1'b0, k == 16});
      end
      if (k == 10) btn_in = 2'b00;
    end
    btn_in = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if ({press_pulse[0], long_pulse[0], repeat_pulse[0]} !== {k == 6, k == 16, k == 19}) begin
        failures++;
        $display("FAIL release_prio_repress k=%0d got=%b exp=%b", k,
                 {press_pulse[0], long_pulse[0], repeat_pulse[0]}, {k == 6, k == 16, k == 19});
      end
    end
    settle();
  endtask

  task automatic test_both();
    btn_in = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({press_pulse, any_press} !== ((k == 6) ? 3'b111 : 3'b000)) begin
        failures++;
        $display("FAIL both_press k=%0d got=%b exp=%b", k, {press_pulse, any_press},
                 (k == 6) ? 3'b111 : 3'b000);
      end
    end
    settle();
  endtask

  task automatic test_reset_held();
    btn_in = 2'b01;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press} !== '0) begin
      failures++;
      $display("FAIL reset_held_clear got=%b exp=0",
               {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({btn_level[0], press_pulse[0], release_pulse[0]} !== {k >= 6, k == 6, 1'b0}) begin
        failures++;
        $display("FAIL reset_held_repress k=%0d got=%b exp=%b", k,
                 {btn_level[0], press_pulse[0], release_pulse[0]}, {k >= 6, k == 6, 1'b0});
      end
    end
    settle();
  endtask

  task automatic test_random();
    int seg [N];
    for (int c = 0; c < N; c++) seg[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press} !==
          {m_level, m_press, m_release, m_long, m_repeat, |m_press}) begin
        failures++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc,
                 {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press},
                 {m_level, m_press, m_release, m_long, m_repeat, |m_press});
      end
      for (int c = 0; c < N; c++) begin
        if (seg[c] == 0) begin
          btn_in[c] = ~btn_in[c];
          seg[c] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 30));
        end else begin
          seg[c] = seg[c] - 1;
        end
      end
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        #1;
        checks++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse} !== '0) begin
          failures++;
          $display("FAIL random_reset cyc=%0d got=%b exp=0", cyc,
                   {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse});
        end
        @(negedge clk);
        rst = 1'b0;
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_hold();
    test_release_on_long();
    test_both();
    test_reset_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
